// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for sub_bytes_seq.
//   in_valid/in_ready/in_inv/in_data    : word offered to the block (byte i = bits [8i+7:8i])
//   out_valid/out_ready/out_data        : substituted word returned downstream
// master = producer/consumer side, slave = the substitution block.
// NBYTES here must match the NBYTES of the sub_bytes_seq it is bound to.
interface sub_bytes_seq_if #(parameter int NBYTES = 16);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_inv;
    logic [8*NBYTES-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_data;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes over an NBYTES-byte word, LANES
// S-boxes per cycle, NBYTES/LANES cycles per word.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sub_bytes_seq_if.slave (in_* accept side, out_* result side)
// Flow: IDLE (in_ready) -> BUSY (one lane group per cycle) -> DONE
// (out_valid, held until out_ready) -> IDLE.

// One S-box lane. The S-box is computed as GF(2^8) inversion plus the
// FIPS-197 affine map rather than a lookup table; the inverse direction
// applies the inverse affine map first and shares the same inverter.
module sub_bytes_lane (
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Multiply in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] y);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] mid;

    always_comb begin
        pre  = inv ? aff_inv(din) : din;
        mid  = gf_inv(pre);
        dout = inv ? mid : aff_fwd(mid);
    end
endmodule

module sub_bytes_seq #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic          clk,
    input  logic          rst,
    sub_bytes_seq_if.slave bus
);
    localparam int STEPS = NBYTES / LANES;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if (NBYTES < 1 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_cfg
        $error("sub_bytes_seq: LANES must be >= 1 and divide NBYTES");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   state, nxt;
    logic [CW-1:0]            cnt;
    logic                     inv_q;
    logic [NBYTES-1:0][7:0]   data_q;
    logic [NBYTES-1:0][7:0]   res_q;
    logic [LANES-1:0][7:0]    lane_in;
    logic [LANES-1:0][7:0]    lane_out;
    logic                     accept;

    assign accept = bus.in_valid & bus.in_ready;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next state
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)       nxt = BUSY;
            BUSY:    if (cnt == LAST_STEP)   nxt = DONE;
            DONE:    if (bus.out_ready)      nxt = IDLE;
            default:                         nxt = IDLE;
        endcase
    end

    // outputs; the result is gated so partial words never leave the block
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_data  = (state == DONE) ? res_q : '0;
    end

    // Lane inputs: the byte group selected by the step counter. Constant
    // indices only; once cnt reaches STEPS nothing matches and lanes see 0.
    always_comb begin
        lane_in = '0;
        for (int k = 0; k < STEPS; k++)
            if (cnt == CW'(k))
                for (int l = 0; l < LANES; l++)
                    lane_in[l] = data_q[k*LANES + l];
    end

    sub_bytes_lane u_lane [LANES-1:0] (
        .inv  (inv_q),
        .din  (lane_in),
        .dout (lane_out)
    );

    // Datapath. cnt counts completed steps and stops at STEPS (never wraps).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            inv_q  <= 1'b0;
            data_q <= '0;
            res_q  <= '0;
        end else if (accept) begin
            cnt    <= '0;
            inv_q  <= bus.in_inv;
            data_q <= bus.in_data;
            res_q  <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CW'(1);
            for (int j = 0; j < NBYTES; j++)
                if (cnt == CW'(j / LANES))
                    res_q[j] <= lane_out[j % LANES];
        end
    end
endmodule
